// File: rtl/ns_tx_arbiter.sv
// ============================================================================
// Module   : ns_tx_arbiter
// Function : Packet-level round-robin arbiter (optional fc strict priority)
//            merging fd/md/fc AXI-Stream sources onto one CMAC TX stream.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ns_tx_arbiter #(
  parameter int DW          = 512,
  parameter int FC_PRIORITY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_enable,

  input  logic [DW-1:0]   axis_fd_tdata,
  input  logic [DW/8-1:0] axis_fd_tkeep,
  input  logic            axis_fd_tlast,
  input  logic            axis_fd_tvalid,
  output logic            axis_fd_tready,

  input  logic [DW-1:0]   axis_md_tdata,
  input  logic [DW/8-1:0] axis_md_tkeep,
  input  logic            axis_md_tlast,
  input  logic            axis_md_tvalid,
  output logic            axis_md_tready,

  input  logic [DW-1:0]   axis_fc_tdata,
  input  logic [DW/8-1:0] axis_fc_tkeep,
  input  logic            axis_fc_tlast,
  input  logic            axis_fc_tvalid,
  output logic            axis_fc_tready,

  output logic [DW-1:0]   axis_tx_tdata,
  output logic [DW/8-1:0] axis_tx_tkeep,
  output logic            axis_tx_tlast,
  output logic            axis_tx_tvalid,
  input  logic            axis_tx_tready,

  output logic [2:0]      grant,
  output logic            busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_grant;
  logic       r_busy;
  logic [1:0] r_last;

  logic [2:0] w_valid;
  logic [1:0] w_base;
  logic [1:0] w_win;
  logic       w_sel_valid;
  logic       w_done;

  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign w_valid = {axis_fc_tvalid, axis_md_tvalid, axis_fd_tvalid};

  // Scan from the highest search offset down so the nearest candidate after last wins.
  always_comb begin
    logic [1:0] cand;
    w_base = (r_last == 2'd0) ? 2'd1 : (r_last == 2'd1) ? 2'd2 : 2'd0;
    w_win  = 2'd0;
    cand   = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = add_mod3(w_base, 2'(k));
      if (w_valid[cand]) w_win = cand;
    end
    if (FC_PRIORITY != 0 && w_valid[2]) w_win = 2'd2;
  end

  always_comb begin
    axis_tx_tdata = '0;
    axis_tx_tkeep = '0;
    axis_tx_tlast = 1'b0;
    w_sel_valid   = 1'b0;
    case (r_grant)
      3'b001: begin
        axis_tx_tdata = axis_fd_tdata;
        axis_tx_tkeep = axis_fd_tkeep;
        axis_tx_tlast = axis_fd_tlast;
        w_sel_valid   = axis_fd_tvalid;
      end
      3'b010: begin
        axis_tx_tdata = axis_md_tdata;
        axis_tx_tkeep = axis_md_tkeep;
        axis_tx_tlast = axis_md_tlast;
        w_sel_valid   = axis_md_tvalid;
      end
      3'b100: begin
        axis_tx_tdata = axis_fc_tdata;
        axis_tx_tkeep = axis_fc_tkeep;
        axis_tx_tlast = axis_fc_tlast;
        w_sel_valid   = axis_fc_tvalid;
      end
      default: ;
    endcase
  end

  // Reset gates the handshake immediately so a packet in flight is cut cleanly.
  assign axis_tx_tvalid = w_sel_valid & ~reset;
  assign axis_fd_tready = r_grant[0] & axis_tx_tready & ~reset;
  assign axis_md_tready = r_grant[1] & axis_tx_tready & ~reset;
  assign axis_fc_tready = r_grant[2] & axis_tx_tready & ~reset;

  assign w_done = axis_tx_tvalid & axis_tx_tready & axis_tx_tlast;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= 3'b000;
      r_busy  <= 1'b0;
      r_last  <= 2'd2;
    end else begin
      case (r_state)
        IDLE: begin
          if (tx_enable && (|w_valid)) begin
            r_state <= BUSY;
            r_grant <= 3'b001 << w_win;
            r_busy  <= 1'b1;
            r_last  <= w_win;
          end
        end
        BUSY: begin
          if (w_done) begin
            r_state <= IDLE;
            r_grant <= 3'b000;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;

endmodule

`default_nettype wire
